// File: rtl/pc_fetch.sv
// Instruction fetch unit: sequences the PC, issues word reads to instruction
// memory, handles jump/branch redirects and hands fetched words to decode.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic [15:0] fetch_count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FETCH   = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;
    localparam logic [1:0] HOLD    = 2'd3;

    logic [1:0]  state_r;
    logic [31:0] pc_r;
    logic [31:0] pend_r;
    logic [31:0] instr_r;
    logic [31:0] instr_pc_r;
    logic        instr_valid_r;
    logic [15:0] fetch_count_r;
    logic        redirect_s;
    logic [31:0] target_s;

    // Redirect selection: jump wins over branch, targets forced word-aligned.
    always_comb begin
        redirect_s = jump | branch_taken;
        if (jump) begin
            target_s = jump_target & 32'hFFFF_FFFC;
        end else begin
            target_s = branch_target & 32'hFFFF_FFFC;
        end
    end

    // Memory request decode; DISCARD replays the address that is still in flight.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_r;
        case (state_r)
            FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc_r;
            end
            DISCARD: begin
                imem_req  = 1'b1;
                imem_addr = pend_r;
            end
            default: begin
                imem_req  = 1'b0;
                imem_addr = pc_r;
            end
        endcase
    end

    // Fetch sequencer state, PC and delivered-instruction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            pc_r          <= RESET_PC;
            pend_r        <= 32'h0000_0000;
            instr_r       <= 32'h0000_0000;
            instr_pc_r    <= 32'h0000_0000;
            instr_valid_r <= 1'b0;
            fetch_count_r <= 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r <= FETCH;
                end
                FETCH: begin
                    if (redirect_s) begin
                        pc_r <= target_s;
                        if (!imem_ack) begin
                            pend_r  <= pc_r;
                            state_r <= DISCARD;
                        end
                    end else if (imem_ack) begin
                        instr_r       <= imem_rdata;
                        instr_pc_r    <= pc_r;
                        instr_valid_r <= 1'b1;
                        pc_r          <= pc_r + 32'd4;
                        state_r       <= HOLD;
                    end
                end
                DISCARD: begin
                    if (redirect_s) begin
                        pc_r <= target_s;
                    end
                    if (imem_ack) begin
                        state_r <= FETCH;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        fetch_count_r <= fetch_count_r + 16'd1;
                    end
                    if (redirect_s) begin
                        pc_r <= target_s;
                    end
                    if (redirect_s || instr_ready) begin
                        instr_valid_r <= 1'b0;
                        state_r       <= FETCH;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign instr_valid = instr_valid_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios followed by random
// traffic, every cycle compared against a flag-based behavioural model.
module tb_pc_fetch;

    localparam logic [31:0] RP = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic [15:0] fetch_count;

    int total = 0;
    int bad = 0;

    // Model: "started" is false for the cycle right after reset, "have" means
    // an instruction is presented to decode, "drop" means an abandoned read
    // is still outstanding at address m_pend.
    bit          m_started;
    bit          m_have;
    bit          m_drop;
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic [15:0] m_count;

    pc_fetch #(.RESET_PC(RP)) dut (
        .clk          (clk),
        .rst          (rst),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_have    = 1'b0;
        m_drop    = 1'b0;
        m_pc      = RP;
        m_pend    = 32'h0;
        m_instr   = 32'h0;
        m_ipc     = 32'h0;
        m_count   = 16'h0;
    endtask

    task automatic model_clock();
        logic        redir;
        logic [31:0] tgt;
        redir = jump | branch_taken;
        tgt   = (jump ? jump_target : branch_target);
        tgt   = {tgt[31:2], 2'b00};
        if (rst) begin
            model_reset();
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (m_have) begin
            if (instr_ready) begin
                m_count = m_count + 16'd1;
                m_have  = 1'b0;
            end
            if (redir) begin
                m_pc   = tgt;
                m_have = 1'b0;
            end
        end else if (m_drop) begin
            if (imem_ack) m_drop = 1'b0;
            if (redir) m_pc = tgt;
        end else begin
            if (redir) begin
                if (!imem_ack) begin
                    m_drop = 1'b1;
                    m_pend = m_pc;
                end
                m_pc = tgt;
            end else if (imem_ack) begin
                m_instr = imem_rdata;
                m_ipc   = m_pc;
                m_have  = 1'b1;
                m_pc    = m_pc + 32'd4;
            end
        end
    endtask

    task automatic compare_all();
        logic exp_req;
        exp_req = m_started && !m_have;
        check_eq("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) check_eq("imem_addr", imem_addr, m_drop ? m_pend : m_pc);
        check_eq("instr_valid", {31'd0, instr_valid}, {31'd0, m_have});
        check_eq("instr", instr, m_instr);
        check_eq("instr_pc", instr_pc, m_ipc);
        check_eq("fetch_count", {16'd0, fetch_count}, {16'd0, m_count});
    endtask

    // One clock: drive inputs, check at negedge, advance model at posedge.
    task automatic step(input logic r, input logic j, input logic [31:0] jt,
                        input logic b, input logic [31:0] bt, input logic a,
                        input logic [31:0] rd, input logic rdy);
        rst = r; jump = j; jump_target = jt; branch_taken = b; branch_target = bt;
        imem_ack = a; imem_rdata = rd; instr_ready = rdy;
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        check_eq("rst_req", {31'd0, imem_req}, 32'd0);
        check_eq("rst_count", {16'd0, fetch_count}, 32'd0);

        // Sequential fetch with PC wrap through zero.
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1111_0000, 1'b1);
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1111_0000 + i, 1'b1);
        check_eq("cnt4", {16'd0, fetch_count}, 32'd4);
        check_eq("addr_wrap", imem_addr, 32'h0000_0008);

        // Ack delayed three cycles at address 8.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hCAFE_0008, 1'b0);
        check_eq("late_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("late_pc", instr_pc, 32'h0000_0008);

        // Decode stalls five cycles.
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h5555_5555, 1'b0);
        check_eq("stall_instr", instr, 32'hCAFE_0008);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        // Branch during un-acked fetch of 0xC, then dropped data.
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0103, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        check_eq("br_addr", imem_addr, 32'h0000_0100);
        check_eq("br_drop", {31'd0, instr_valid}, 32'd0);

        // Jump and branch together with ack: jump wins, data dropped.
        step(1'b0, 1'b1, 32'h0000_0207, 1'b1, 32'h0000_0300, 1'b1, 32'hBAD0_0000, 1'b0);
        check_eq("jmp_addr", imem_addr, 32'h0000_0204);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0204, 1'b0);

        // Reset while holding an instruction.
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        check_eq("rh_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rh_count", {16'd0, fetch_count}, 32'd0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        check_eq("rh_addr", imem_addr, RP);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) == 0), $urandom(),
                 ($urandom_range(0, 7) == 0), $urandom(),
                 ($urandom_range(0, 2) != 0), $urandom(),
                 ($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC value loaded by reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: branch_taken  input  1  redirect to branch_target.
REQ-005 SHALL have port: branch_target  input  32  branch destination.
REQ-006 SHALL have port: jump  input  1  redirect to jump_target.
REQ-007 SHALL have port: jump_target  input  32  jump destination.
REQ-008 SHALL have port: imem_req  output  1  instruction-memory read request.
REQ-009 SHALL have port: imem_addr  output  32  word address of request.
REQ-010 SHALL have port: imem_ack  input  1  read data valid this cycle.
REQ-011 SHALL have port: imem_rdata  input  32  read data.
REQ-012 SHALL have port: instr_valid  output  1  instr/instr_pc hold a fetched instruction.
REQ-013 SHALL have port: instr  output  32  fetched instruction word.
REQ-014 SHALL have port: instr_pc  output  32  address of instr.
REQ-015 SHALL have port: instr_ready  input  1  decode accepts instr this cycle.
REQ-016 SHALL have port: fetch_count  output  16  count of instructions delivered.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, DISCARD, HOLD; all outputs except imem_req/imem_addr registered.
REQ-018 SHALL derive imem_req = 1 in FETCH or DISCARD, 0 otherwise; imem_addr = pc register in FETCH, latched pending address in DISCARD.
REQ-019 SHALL hold imem_addr stable while imem_req=1 and imem_ack=0.
REQ-020 SHALL move IDLE -> FETCH unconditionally on the first cycle after rst deasserts.
REQ-021 SHALL, in FETCH with imem_ack=1 and no redirect: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4, state->HOLD (1-cycle latency ack->instr_valid).
REQ-022 SHALL accept imem_ack in the same cycle imem_req first asserts.
REQ-023 SHALL, in HOLD, keep instr/instr_pc/instr_valid stable until instr_ready=1; on instr_ready: instr_valid<=0, fetch_count+=1, state->FETCH.
REQ-024 SHALL treat instr_ready as don't-care when instr_valid=0.
REQ-025 SHALL prioritise redirects jump > branch_taken > sequential; redirect target has bits [1:0] forced to 2'b00.
REQ-026 SHALL, on redirect in FETCH with imem_ack=0: latch pending address, pc<=target, state->DISCARD.
REQ-027 SHALL, in DISCARD, keep request until imem_ack, drop that data, then state->FETCH at pc; further redirects in DISCARD only update pc.
REQ-028 SHALL, on redirect in FETCH coinciding with imem_ack: discard data, pc<=target, stay FETCH.
REQ-029 SHALL, on redirect in HOLD: instr_valid<=0, pc<=target, state->FETCH; if instr_ready=1 same cycle, count the delivery (fetch_count+=1) first.
REQ-030 SHALL wrap pc+4 from 32'hFFFF_FFFC to 32'h0000_0000 and fetch_count from 16'hFFFF to 0.
REQ-031 SHALL ignore redirects in IDLE and while rst=1.

Reset
REQ-032 SHALL, while rst=1 at posedge: state<=IDLE, pc<=RESET_PC, instr_valid<=0, instr<=0, instr_pc<=0, fetch_count<=0; imem_req=0.
REQ-033 SHALL abandon any outstanding request on reset mid-operation; late imem_ack after reset is ignored until FETCH.

Verification
REQ-034 Reset release, ack every request, instr_ready=1 -> imem_addr sequence 0,4,8,C; instr_pc matches; fetch_count=4 after 4 deliveries.
REQ-035 Ack delayed 3 cycles at addr 8 -> imem_addr stays 8 with imem_req=1 for 4 cycles; instr_valid one cycle after ack.
REQ-036 instr_ready=0 for 5 cycles in HOLD -> instr, instr_pc, instr_valid unchanged; no new imem_req.
REQ-037 branch_taken=1, target 32'h0000_0103, during un-acked fetch of 0x10 -> DISCARD; rdata on ack dropped; next request addr 0x100; jump+branch same cycle -> jump_target wins.
REQ-038 RESET_PC=32'hFFFF_FFFC, ack -> next imem_addr 0x0; rst asserted in HOLD -> instr_valid=0, fetch_count=0, pc=RESET_PC next cycle.
